calc_pipe_top: RTL and testbench

CALC_PIPE_TOP -- requirements
Module: calc_pipe_top

---
 rtl/calc_pipe_pkg.sv | 15 +
 rtl/calc_pipe_stage.sv | 40 ++++
 rtl/calc_pipe_top.sv | 123 ++++++++++++
 tb/tb_calc_pipe_top.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pipe_pkg.sv
// Shared definitions for the two-stage add/multiply/accumulate pipe:
// mode encodings and the default result-width derivation.
package calc_pipe_pkg;

    localparam logic [1:0] MODE_PROD = 2'b00;
    localparam logic [1:0] MODE_ACC  = 2'b01;
    localparam logic [1:0] MODE_SUM  = 2'b10;
    // Reserved encoding, executed as a product.
    localparam logic [1:0] MODE_RSVD = 2'b11;

    function automatic int calc_out_w(input int data_w);
        return 2 * data_w + 4;
    endfunction

endpackage

// File: rtl/calc_pipe_stage.sv
// Purpose: one pipeline slot, a valid bit plus data register with load/hold control.
// Latency: 1 cycle from upstream accept to downstream visibility.
// Backpressure: accepts when empty or when its content leaves the same cycle.
module calc_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_vld,
    output logic         up_rdy,
    input  logic [W-1:0] up_dat,
    output logic         dn_vld,
    input  logic         dn_rdy,
    output logic [W-1:0] dn_dat
);

    logic         vld_q, vld_d;
    logic [W-1:0] dat_q, dat_d;

    always_comb begin
        up_rdy = !vld_q || dn_rdy;
        vld_d  = up_rdy ? up_vld : vld_q;
        // Data only moves on a real handshake so a held result never changes.
        dat_d  = (up_rdy && up_vld) ? up_dat : dat_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign dn_vld = vld_q;
    assign dn_dat = dat_q;

endmodule

// File: rtl/calc_pipe_top.sv
// Purpose: operand add/sub stage, then product / sum / accumulate stage with overflow flag.
// Latency: 2 cycles from input handshake to out_valid when not stalled.
// Backpressure: out_ready low holds the result; in_ready drops once both stages are full.
module calc_pipe_top #(
    parameter int DATA_W = 2,
    parameter int OUT_W  = calc_pipe_pkg::calc_out_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_add_a,
    input  logic [DATA_W-1:0] in_add_b,
    input  logic [DATA_W-1:0] in_add_c,
    input  logic [DATA_W-1:0] in_add_d,
    input  logic              in_add_sub_sel,
    input  logic [1:0]        in_mode,
    input  logic              in_acc_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  final_cal_out,
    output logic              out_ovf
);
    import calc_pipe_pkg::*;

    localparam int SW = DATA_W + 2;
    localparam int PW = 2 * SW;
    // Wide enough to hold accumulator + product exactly.
    localparam int XW = ((OUT_W > PW) ? OUT_W : PW) + 1;

    typedef struct packed {
        logic [1:0]           mode;
        logic                 clr;
        logic signed [SW-1:0] s0;
        logic signed [SW-1:0] s1;
    } s1_t;

    typedef struct packed {
        logic             ovf;
        logic [OUT_W-1:0] res;
    } s2_t;

    logic [SW-1:0] a_x, b_x, c_x, d_x;
    s1_t           s1_in, s1_dat;
    s2_t           s2_in, s2_dat;
    logic          s1_vld, s2_up_rdy, acc_fire;

    logic signed [XW-1:0] e0, e1, eacc, prod, exact;
    logic [OUT_W-1:0]     sum;
    logic [OUT_W-1:0]     acc_q, acc_d;

    always_comb begin
        a_x = {2'b00, in_add_a};
        b_x = {2'b00, in_add_b};
        c_x = {2'b00, in_add_c};
        d_x = {2'b00, in_add_d};
        s1_in      = '0;
        s1_in.mode = in_mode;
        s1_in.clr  = in_acc_clr;
        s1_in.s0   = in_add_sub_sel ? (a_x - b_x) : (a_x + b_x);
        s1_in.s1   = in_add_sub_sel ? (c_x - d_x) : (c_x + d_x);
    end

    calc_pipe_stage #(.W($bits(s1_t))) u_stage1 (
        .clk    (clk),
        .rst    (rst),
        .up_vld (in_valid),
        .up_rdy (in_ready),
        .up_dat (s1_in),
        .dn_vld (s1_vld),
        .dn_rdy (s2_up_rdy),
        .dn_dat (s1_dat)
    );

    assign acc_fire = s1_vld && s2_up_rdy && (s1_dat.mode == MODE_ACC);

    always_comb begin
        e0    = {{(XW-SW){s1_dat.s0[SW-1]}}, s1_dat.s0};
        e1    = {{(XW-SW){s1_dat.s1[SW-1]}}, s1_dat.s1};
        eacc  = s1_dat.clr ? '0 : {{(XW-OUT_W){acc_q[OUT_W-1]}}, acc_q};
        prod  = e0 * e1;
        exact = eacc + prod;
        sum   = e0[OUT_W-1:0] + e1[OUT_W-1:0];
        s2_in = '0;
        acc_d = acc_q;
        case (s1_dat.mode)
            MODE_ACC: begin
                s2_in.res = exact[OUT_W-1:0];
                // Overflow when the bits above the result's sign are not all copies of it.
                s2_in.ovf = (exact[XW-1:OUT_W-1] != {(XW-OUT_W+1){exact[OUT_W-1]}});
                if (acc_fire) begin
                    acc_d = exact[OUT_W-1:0];
                end
            end
            MODE_SUM:             s2_in.res = sum;
            MODE_PROD, MODE_RSVD: s2_in.res = prod[OUT_W-1:0];
            default:              s2_in.res = prod[OUT_W-1:0];
        endcase
    end

    calc_pipe_stage #(.W($bits(s2_t))) u_stage2 (
        .clk    (clk),
        .rst    (rst),
        .up_vld (s1_vld),
        .up_rdy (s2_up_rdy),
        .up_dat (s2_in),
        .dn_vld (out_valid),
        .dn_rdy (out_ready),
        .dn_dat (s2_dat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign final_cal_out = s2_dat.res;
    assign out_ovf       = s2_dat.ovf;

endmodule

// File: tb/tb_calc_pipe_top.sv
// Bench for calc_pipe_top at DATA_W=2, OUT_W=8: directed table, stall, mid-run reset, sweep.
module tb_calc_pipe_top;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] in_add_a = '0, in_add_b = '0, in_add_c = '0, in_add_d = '0;
    logic       in_add_sub_sel = 1'b0;
    logic [1:0] in_mode = '0;
    logic       in_acc_clr = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] final_cal_out;
    logic       out_ovf;

    calc_pipe_top #(.DATA_W(2), .OUT_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_add_a       (in_add_a),
        .in_add_b       (in_add_b),
        .in_add_c       (in_add_c),
        .in_add_d       (in_add_d),
        .in_add_sub_sel (in_add_sub_sel),
        .in_mode        (in_mode),
        .in_acc_clr     (in_acc_clr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .final_cal_out  (final_cal_out),
        .out_ovf        (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] a, b, c, d;
        logic       sel;
        logic [1:0] mode;
        logic       clr;
        logic [7:0] res;
        logic       ovf;
    } vec_t;

    typedef struct {
        logic [7:0] res;
        logic       ovf;
        int         acc_cyc;
        bit         chk_lat;
    } exp_t;

    exp_t       sbq[$];
    int         n_vec = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         acc_m = 0;
    bit         lat_chk = 0;
    bit         tab_en = 0;
    logic [7:0] tab_res = '0;
    logic       tab_ovf = 1'b0;
    bit         hold_prev = 0;
    logic [7:0] hold_dat = '0;
    logic       hold_ovf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Integer reference; accumulator kept as an 8-bit signed value.
    function automatic void model(input int a, input int b, input int c, input int d,
                                  input bit sel, input int mode, input bit clr,
                                  output logic [7:0] r, output logic o);
        int s0;
        int s1;
        int x;
        s0 = sel ? a - b : a + b;
        s1 = sel ? c - d : c + d;
        o  = 1'b0;
        if (mode == 1) begin
            x = (clr ? 0 : acc_m) + s0 * s1;
            o = (x > 127) || (x < -128);
            r = x[7:0];
            acc_m = $signed(r);
        end else if (mode == 2) begin
            x = s0 + s1;
            r = x[7:0];
        end else begin
            x = s0 * s1;
            r = x[7:0];
        end
    endfunction

    // Called right after inputs are set following a negedge; evaluates this slot's handshakes.
    task automatic sample(output bit accepted);
        #1;
        cyc++;
        if (hold_prev) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(final_cal_out), 32'(hold_dat));
            chk("hold_ovf", 32'(out_ovf), 32'(hold_ovf));
        end
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected_output", 32'(final_cal_out), 32'hDEAD);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("result", 32'(final_cal_out), 32'(e.res));
                chk("ovf", 32'(out_ovf), 32'(e.ovf));
                if (e.chk_lat) chk("latency", 32'(cyc - e.acc_cyc), 32'd2);
            end
        end
        hold_prev = out_valid && !out_ready;
        hold_dat  = final_cal_out;
        hold_ovf  = out_ovf;
        accepted  = in_valid && in_ready;
        if (accepted) begin
            exp_t       e;
            logic [7:0] r;
            logic       o;
            model(int'(in_add_a), int'(in_add_b), int'(in_add_c), int'(in_add_d),
                  in_add_sub_sel, int'(in_mode), in_acc_clr, r, o);
            if (tab_en) begin
                r = tab_res;
                o = tab_ovf;
            end
            e.res = r;
            e.ovf = o;
            e.acc_cyc = cyc;
            e.chk_lat = lat_chk;
            sbq.push_back(e);
        end
    endtask

    task automatic drive_beat(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                              input logic [1:0] d, input logic sel, input logic [1:0] mode,
                              input logic clr);
        in_add_a = a; in_add_b = b; in_add_c = c; in_add_d = d;
        in_add_sub_sel = sel; in_mode = mode; in_acc_clr = clr;
    endtask

    task automatic drain();
        bit acc;
        int n;
        n = 0;
        while ((n < 4 || sbq.size() != 0) && n < 100) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            sample(acc);
            n++;
        end
        if (sbq.size() != 0) begin
            chk("drain_timeout", 32'(sbq.size()), 32'd0);
            sbq.delete();
        end
    endtask

    initial begin
        vec_t       tab[10];
        bit         acc;
        int         n_acc;
        logic [8:0] vb;

        tab[0] = '{2'd3, 2'd1, 2'd2, 2'd0, 1'b0, 2'b00, 1'b0, 8'h08, 1'b0};
        tab[1] = '{2'd0, 2'd3, 2'd3, 2'd0, 1'b1, 2'b00, 1'b0, 8'hF7, 1'b0};
        tab[2] = '{2'd0, 2'd3, 2'd3, 2'd0, 1'b1, 2'b10, 1'b0, 8'h00, 1'b0};
        tab[3] = '{2'd3, 2'd1, 2'd2, 2'd0, 1'b0, 2'b11, 1'b0, 8'h08, 1'b0};
        tab[4] = '{2'd1, 2'd3, 2'd0, 2'd3, 1'b1, 2'b10, 1'b0, 8'hFB, 1'b0};
        tab[5] = '{2'd0, 2'd3, 2'd0, 2'd3, 1'b1, 2'b00, 1'b0, 8'h09, 1'b0};
        tab[6] = '{2'd3, 2'd3, 2'd3, 2'd3, 1'b0, 2'b01, 1'b1, 8'h24, 1'b0};
        tab[7] = '{2'd3, 2'd3, 2'd3, 2'd3, 1'b0, 2'b01, 1'b0, 8'h48, 1'b0};
        tab[8] = '{2'd3, 2'd3, 2'd3, 2'd3, 1'b0, 2'b01, 1'b0, 8'h6C, 1'b0};
        tab[9] = '{2'd3, 2'd3, 2'd3, 2'd3, 1'b0, 2'b01, 1'b0, 8'h90, 1'b1};

        // Reset state, while held and on the first edge after release.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(final_cal_out), 32'd0);
        chk("rst_ovf", 32'(out_ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);

        // Directed table, out_ready high, latency checked on every beat.
        lat_chk = 1;
        tab_en  = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive_beat(tab[i].a, tab[i].b, tab[i].c, tab[i].d, tab[i].sel, tab[i].mode, tab[i].clr);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            tab_res   = tab[i].res;
            tab_ovf   = tab[i].ovf;
            sample(acc);
            chk("tab_accept", 32'(acc), 32'd1);
        end
        tab_en = 0;
        drain();
        lat_chk = 0;

        // Stall: out_ready low for 5 slots with in_valid held high.
        n_acc = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive_beat(2'(n_acc + 1), 2'd0, 2'd1, 2'd1, 1'b0, 2'b00, 1'b0);
            in_valid  = 1'b1;
            out_ready = 1'b0;
            sample(acc);
            if (acc) n_acc++;
            if (k >= 2) chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        chk("stall_accepts", 32'(n_acc), 32'd2);
        drain();

        // Reset with both stages full, accumulator already loaded.
        @(negedge clk);
        drive_beat(2'd3, 2'd3, 2'd3, 2'd3, 1'b0, 2'b01, 1'b1);
        in_valid = 1'b1; out_ready = 1'b0;
        sample(acc);
        @(negedge clk);
        drive_beat(2'd1, 2'd1, 2'd1, 2'd1, 1'b0, 2'b00, 1'b0);
        sample(acc);
        @(negedge clk);
        in_valid = 1'b0;
        sample(acc);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_result", 32'(final_cal_out), 32'd0);
        sbq.delete();
        hold_prev = 0;
        acc_m = 0;
        @(negedge clk);
        rst = 1'b0;
        drive_beat(2'd3, 2'd3, 2'd3, 2'd3, 1'b0, 2'b01, 1'b0);
        in_valid = 1'b1; out_ready = 1'b1;
        tab_en = 1; tab_res = 8'h24; tab_ovf = 1'b0;
        sample(acc);
        chk("midrst_accept", 32'(acc), 32'd1);
        tab_en = 0;
        drain();

        // Exhaustive operand/sel sweep per mode with random flow control.
        for (int m = 0; m < 4; m++) begin
            for (int v = 0; v < 512; v++) begin
                int tries;
                logic clr;
                vb = 9'(v);
                clr = ($urandom_range(0, 15) == 0);
                acc = 0;
                tries = 0;
                while (!acc && tries < 50) begin
                    @(negedge clk);
                    drive_beat(vb[1:0], vb[3:2], vb[5:4], vb[7:6], vb[8], 2'(m), clr);
                    in_valid  = ($urandom_range(0, 3) != 0);
                    out_ready = ($urandom_range(0, 3) != 0);
                    sample(acc);
                    tries++;
                end
                if (!acc) chk("sweep_accept_timeout", 32'(tries), 32'd0);
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
